// File: rtl/sd_sample_pacer.sv
// sd_sample_pacer: buffers a bursty byte stream in a small FIFO and releases
// one byte every SAMPLE_DIV clocks as a held sample with a one-cycle strobe.
// The output stays at 0 until the first real sample is released. Every release
// slot that finds the FIFO empty is counted as an underrun.
module sd_sample_pacer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned SAMPLE_DIV = 96,
  parameter int unsigned PRIME      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               sample_out,
  output logic                     sample_strobe,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [15:0]              underrun_cnt,
  output logic                     playing
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [1:0] {
    S_PRIME   = 2'd0,
    S_PLAY    = 2'd1,
    S_STARVED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   div_q, div_d;
  logic [7:0]      sample_q, sample_d;
  logic            strobe_q, strobe_d;
  logic [15:0]     under_q, under_d;
  logic [7:0]      mem [DEPTH];

  logic push;
  logic pop;
  logic slot;
  logic primed;

  // Handshake and release-slot decode
  always_comb begin
    in_ready = (count_q != CW'(DEPTH)) && !rst;
    push     = in_valid && in_ready;
    primed   = (count_q >= CW'(PRIME)) && enable;
    slot     = (state_q == S_PLAY) && enable && (div_q == DW'(SAMPLE_DIV - 1));
    pop      = slot && (count_q != '0);
  end

  // FIFO storage; contents need no reset because pointers and count do
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // Next-state, divider, FIFO bookkeeping and sample output
  always_comb begin
    state_d  = state_q;
    div_d    = '0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sample_d = sample_q;
    strobe_d = 1'b0;
    under_d  = under_q;

    case (state_q)
      S_PRIME: begin
        if (primed) begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (!enable) begin
          state_d = S_PRIME;
        end else begin
          div_d = slot ? '0 : div_q + DW'(1);
          if (slot && !pop) begin
            // Empty at the slot: hold the sample, count it, wait for refill
            if (under_q != 16'hFFFF) begin
              under_d = under_q + 16'd1;
            end
            state_d = S_STARVED;
          end
        end
      end
      S_STARVED: begin
        if (!enable) begin
          state_d = S_PRIME;
        end else if (primed) begin
          state_d = S_PLAY;
        end
      end
      default: begin
        state_d = S_PRIME;
      end
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      sample_d = mem[rd_ptr_q];
      strobe_d = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State and datapath registers; reset empties the FIFO immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_PRIME;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      div_q    <= '0;
      sample_q <= 8'h00;
      strobe_q <= 1'b0;
      under_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      div_q    <= div_d;
      sample_q <= sample_d;
      strobe_q <= strobe_d;
      under_q  <= under_d;
    end
  end

  assign sample_out    = sample_q;
  assign sample_strobe = strobe_q;
  assign fill_level    = count_q;
  assign underrun_cnt  = under_q;
  assign playing       = (state_q == S_PLAY);

endmodule

// File: tb/tb_sd_sample_pacer.sv
// Bench for sd_sample_pacer: directed stimulus, expected sample values queued
// on every accepted push and checked by a strobe monitor.
module tb_sd_sample_pacer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  sample_out;
  logic        sample_strobe;
  logic [4:0]  fill_level;
  logic [15:0] underrun_cnt;
  logic        playing;

  int n_tests;
  int n_fail;
  int cyc;
  int last_cyc;
  bit spacing_on;
  logic [7:0] exp_q [$];

  sd_sample_pacer #(
    .DEPTH(16),
    .SAMPLE_DIV(96),
    .PRIME(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sample_out(sample_out),
    .sample_strobe(sample_strobe),
    .fill_level(fill_level),
    .underrun_cnt(underrun_cnt),
    .playing(playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until accepted (bounded)
  task automatic push_byte(input logic [7:0] b, input bit expect_out);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("push_timeout", 32'(in_ready), 32'd1);
    end else begin
      if (expect_out) exp_q.push_back(b);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string name);
    int n;
    n = 0;
    tick();
    while (!sample_strobe && n < 300) begin
      tick();
      n++;
    end
    if (!sample_strobe) chk(name, 32'(sample_strobe), 32'd1);
  endtask

  // Scoreboard monitor: each strobe must carry the next queued byte
  always @(negedge clk) begin
    if (!rst && sample_strobe) begin
      if (exp_q.size() == 0) begin
        chk("strobe_unexpected", 32'(sample_strobe), 32'd0);
      end else begin
        chk("sample_value", 32'(sample_out), 32'(exp_q.pop_front()));
      end
      if (spacing_on) chk("strobe_spacing", 32'(cyc - last_cyc), 32'd96);
      last_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 100000", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    bit strobe_seen;

    n_tests    = 0;
    n_fail     = 0;
    cyc        = 0;
    last_cyc   = 0;
    spacing_on = 1'b0;
    rst        = 1'b1;
    enable     = 1'b0;
    in_data    = 8'h00;
    in_valid   = 1'b0;

    // Reset and prime
    tick();
    chk("ready_in_reset", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);
    chk("reset_sample", 32'(sample_out), 32'h00);
    chk("reset_strobe", 32'(sample_strobe), 32'd0);
    chk("reset_fill", 32'(fill_level), 32'd0);
    chk("reset_underrun", 32'(underrun_cnt), 32'd0);
    chk("reset_playing", 32'(playing), 32'd0);

    enable = 1'b1;
    for (int i = 1; i <= 7; i++) push_byte(8'(i), 1'b1);
    tick();
    chk("prime7_fill", 32'(fill_level), 32'd7);
    chk("prime7_playing", 32'(playing), 32'd0);
    chk("prime7_sample", 32'(sample_out), 32'h00);
    push_byte(8'h08, 1'b1);
    chk("prime8_not_yet", 32'(playing), 32'd0);
    tick();
    chk("prime8_playing", 32'(playing), 32'd1);
    t0 = cyc;
    wait_strobe("first_strobe_timeout");
    chk("first_strobe_latency", 32'(cyc - t0), 32'd96);
    chk("first_sample", 32'(sample_out), 32'h01);
    tick();
    spacing_on = 1'b1;

    // Steady stream: one new byte per released sample
    for (int i = 0; i < 20; i++) begin
      push_byte(8'(8'h10 + i), 1'b1);
      wait_strobe("steady_strobe_timeout");
    end
    chk("steady_underrun", 32'(underrun_cnt), 32'd0);
    chk("steady_fill", 32'(fill_level), 32'd7);

    // Async reset mid-play with five bytes buffered
    wait_strobe("drain_strobe_timeout");
    wait_strobe("drain_strobe_timeout");
    tick();
    spacing_on = 1'b0;
    chk("pre_reset_fill", 32'(fill_level), 32'd5);
    chk("pre_reset_playing", 32'(playing), 32'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_ready", 32'(in_ready), 32'd0);
    chk("async_sample", 32'(sample_out), 32'h00);
    chk("async_strobe", 32'(sample_strobe), 32'd0);
    chk("async_fill", 32'(fill_level), 32'd0);
    chk("async_underrun", 32'(underrun_cnt), 32'd0);
    chk("async_playing", 32'(playing), 32'd0);
    enable = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Full backpressure with playback paused
    for (int i = 0; i < 16; i++) push_byte(8'(8'hA0 + i), 1'b1);
    chk("full_fill", 32'(fill_level), 32'd16);
    chk("full_ready", 32'(in_ready), 32'd0);
    in_data  = 8'hEE;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("full_17th_rejected", 32'(fill_level), 32'd16);
    chk("full_still_paused", 32'(playing), 32'd0);
    enable = 1'b1;
    tick();
    chk("full_playing", 32'(playing), 32'd1);
    chk("full_ready_before_pop", 32'(in_ready), 32'd0);
    wait_strobe("full_strobe_timeout");
    chk("full_ready_after_pop", 32'(in_ready), 32'd1);
    chk("full_fill_after_pop", 32'(fill_level), 32'd15);

    #2;
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();

    // Underrun and resume
    for (int i = 1; i <= 8; i++) push_byte(8'(8'h30 + i), 1'b1);
    for (int i = 0; i < 8; i++) wait_strobe("under_strobe_timeout");
    n = 0;
    strobe_seen = 1'b0;
    while (underrun_cnt == 16'd0 && n < 300) begin
      tick();
      n++;
      if (sample_strobe) strobe_seen = 1'b1;
    end
    chk("under_slot_delay", 32'(n), 32'd96);
    chk("under_count", 32'(underrun_cnt), 32'd1);
    chk("under_no_strobe", 32'(strobe_seen), 32'd0);
    chk("under_sample_held", 32'(sample_out), 32'h38);
    chk("under_starved", 32'(playing), 32'd0);
    chk("under_fill", 32'(fill_level), 32'd0);

    for (int i = 1; i <= 7; i++) push_byte(8'(8'h40 + i), 1'b1);
    push_byte(8'h00, 1'b1);
    n = 0;
    while (!playing && n < 300) begin
      tick();
      n++;
    end
    chk("resume_latency", 32'(n), 32'd1);
    t0 = cyc;
    wait_strobe("resume_strobe_timeout");
    chk("resume_first_strobe", 32'(cyc - t0), 32'd96);
    chk("resume_first_sample", 32'(sample_out), 32'h41);

    // Zero byte, then a push landing exactly on an empty release slot
    for (int i = 0; i < 7; i++) wait_strobe("zero_strobe_timeout");
    chk("zero_byte_out", 32'(sample_out), 32'h00);
    chk("zero_fill", 32'(fill_level), 32'd0);
    repeat (95) tick();
    chk("slot_no_early_underrun", 32'(underrun_cnt), 32'd1);
    chk("slot_still_playing", 32'(playing), 32'd1);
    in_data  = 8'h77;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("slot_underrun", 32'(underrun_cnt), 32'd2);
    chk("slot_fill", 32'(fill_level), 32'd1);
    chk("slot_no_strobe", 32'(sample_strobe), 32'd0);
    chk("slot_sample_held", 32'(sample_out), 32'h00);
    chk("slot_starved", 32'(playing), 32'd0);
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
